// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-FSM states, widths and the parity rule used by both TX and RX.
// Pure declarations; no latency or backpressure of its own.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int DIV_W     = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  // parity_sel=1 gives even parity (^data), 0 gives odd parity (~^data).
  function automatic logic uart_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 parity_sel);
    return parity_sel ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..divisor-1 and pulses tick on the last count.
// Tick is decoded from the count register; clear restarts the period on the next edge.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;

  // divisor is always >= 1 here, so divisor-1 cannot wrap.
  assign tick = (count_q == (divisor - DIV_W'(1)));

  always_comb begin
    count_d = count_q + DIV_W'(1);
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register feeding a start/8 data/parity/1-2 stop serialiser.
// tx falls one cycle after acceptance when idle; ready_out is low while the holding register is full.
module uart_tx
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic [DIV_W-1:0]     baud_divisor,
  input  logic                 parity_sel,
  input  logic                 stop_sel,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  uart_tx_state_t       state_q, state_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] hold_dat_q, hold_dat_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 last_stop;
  logic                 start_frame;

  assign ready_out   = ~hold_full_q;
  assign busy        = (state_q != ST_IDLE);
  assign tx          = tx_q;
  assign last_stop   = ~stop2_q | stop_cnt_q;
  assign tx_done     = (state_q == ST_STOP) && tick && last_stop;
  assign start_frame = tx_en && hold_full_q && ((state_q == ST_IDLE) || tx_done);

  uart_baud_gen u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_frame),
    .divisor (div_q),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_dat_d  = hold_dat_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    stop_cnt_d  = stop_cnt_q;
    div_d       = div_q;
    tx_d        = 1'b1;

    if (start_frame) begin
      hold_full_d = 1'b0;
    end else if (valid_in && ready_out) begin
      hold_full_d = 1'b1;
      hold_dat_d  = data_in;
    end

    // Everything the frame depends on is captured here, so input changes mid-frame are ignored.
    if (start_frame) begin
      state_d    = ST_START;
      shift_d    = hold_dat_q;
      bit_idx_d  = '0;
      par_d      = uart_parity(hold_dat_q, parity_sel);
      stop2_d    = stop_sel;
      stop_cnt_d = 1'b0;
      div_d      = (baud_divisor == '0) ? DIV_W'(1) : baud_divisor;
    end else if (tick) begin
      case (state_q)
        ST_START: state_d = ST_DATA;
        ST_DATA: begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        ST_PARITY: state_d = ST_STOP;
        ST_STOP: begin
          if (!last_stop) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_dat_q  <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      par_q       <= 1'b0;
      stop2_q     <= 1'b0;
      stop_cnt_q  <= 1'b0;
      div_q       <= DIV_W'(1);
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_dat_q  <= hold_dat_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      par_q       <= par_d;
      stop2_q     <= stop2_d;
      stop_cnt_q  <= stop_cnt_d;
      div_q       <= div_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed plus randomized checks of uart_tx against a per-bit frame model.
// All sampling and driving happens on the falling clock edge.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic [11:0] baud_divisor;
  logic        parity_sel;
  logic        stop_sel;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_out;
  logic        tx;
  logic        busy;
  logic        tx_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk          (clk),
    .reset        (rst_n),
    .tx_en        (tx_en),
    .baud_divisor (baud_divisor),
    .parity_sel   (parity_sel),
    .stop_sel     (stop_sel),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge just after the accepting clock edge.
  task automatic push(input logic [7:0] b);
    int n = 0;
    data_in  = b;
    valid_in = 1'b1;
    while (!ready_out && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_timeout", 32'(n < 20000), 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Model: a frame is a list of line levels, each held for eff_div cycles.
  // pend: a second byte is offered, so ready_out drops after the first start-bit cycle.
  // mut:  halfway through, scramble the config inputs and drop tx_en.
  task automatic check_frame(input logic [7:0] b, input int div, input bit psel,
                             input bit ssel, input bit pend, input bit mut,
                             input int max_wait);
    int   eff;
    int   len;
    int   w;
    int   ones;
    logic exp_bits[12];
    eff  = (div == 0) ? 1 : div;
    len  = (11 + int'(ssel)) * eff;
    ones = $countones(b);
    exp_bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) exp_bits[1 + j] = b[j];
    exp_bits[9]  = psel ? logic'(ones % 2) : logic'(1 - ones % 2);
    exp_bits[10] = 1'b1;
    exp_bits[11] = 1'b1;

    w = 0;
    @(negedge clk);
    while (tx !== 1'b0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    chk("start_bit_seen", 32'(tx), 32'd0);
    for (int i = 0; i < len; i++) begin
      chk("tx_level", 32'(tx), 32'(exp_bits[i / eff]));
      chk("tx_done", 32'(tx_done), 32'(i == len - 1));
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("ready_in_frame", 32'(ready_out), pend ? 32'(i == 0) : 32'd1);
      if (mut && i == len / 2) begin
        baud_divisor = 12'(eff + 3);
        parity_sel   = ~parity_sel;
        stop_sel     = ~stop_sel;
        tx_en        = 1'b0;
      end
      if (i < len - 1) @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_tx"}, 32'(tx), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    int         rdiv;
    bit         rp;
    bit         rs;

    rst_n        = 1'b0;
    tx_en        = 1'b1;
    baud_divisor = 12'd4;
    parity_sel   = 1'b1;
    stop_sel     = 1'b0;
    data_in      = 8'h00;
    valid_in     = 1'b0;

    // Reset values
    #12;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, even parity, one stop
    baud_divisor = 12'd4; parity_sel = 1'b1; stop_sel = 1'b0;
    push(8'hA5);
    check_frame(8'hA5, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_idle("a5_after");

    // Odd parity, two stops
    baud_divisor = 12'd3; parity_sel = 1'b0; stop_sel = 1'b1;
    push(8'h01);
    check_frame(8'h01, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check_idle("odd2_after");

    // Back-to-back: second byte is held while the first is on the line
    baud_divisor = 12'd2; parity_sel = 1'b1; stop_sel = 1'b0;
    push(8'h55);
    data_in  = 8'hAA;
    valid_in = 1'b1;
    check_frame(8'h55, 2, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    valid_in = 1'b0;
    check_frame(8'hAA, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_idle("b2b_after");

    // tx_en gating, then mid-frame tx_en drop and config changes
    tx_en = 1'b0;
    baud_divisor = 12'd2; parity_sel = 1'b1; stop_sel = 1'b1;
    push(8'h3C);
    for (int i = 0; i < 8; i++) begin
      chk("gated_tx", 32'(tx), 32'd1);
      chk("gated_ready", 32'(ready_out), 32'd0);
      chk("gated_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    tx_en = 1'b1;
    check_frame(8'h3C, 2, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    check_idle("txen_drop_after");
    tx_en = 1'b1;

    // Divisor 0 and 1 both give one cycle per bit
    baud_divisor = 12'd0; parity_sel = 1'b0; stop_sel = 1'b0;
    push(8'hC3);
    check_frame(8'hC3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_idle("div0_after");
    baud_divisor = 12'd1; parity_sel = 1'b1; stop_sel = 1'b1;
    push(8'h7E);
    check_frame(8'h7E, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check_idle("div1_after");

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      rb   = 8'($urandom_range(0, 255));
      rdiv = int'($urandom_range(0, 6));
      rp   = 1'($urandom_range(0, 1));
      rs   = 1'($urandom_range(0, 1));
      baud_divisor = 12'(rdiv); parity_sel = rp; stop_sel = rs;
      push(rb);
      check_frame(rb, rdiv, rp, rs, 1'b0, 1'b0, 0);
      check_idle("rand_after");
    end

    // Reset mid-frame with a second byte pending
    baud_divisor = 12'd4; parity_sel = 1'b1; stop_sel = 1'b0;
    push(8'hF0);
    data_in  = 8'h0F;
    valid_in = 1'b1;
    repeat (10) @(negedge clk);
    valid_in = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_ready", 32'(ready_out), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_ready", 32'(ready_out), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_idle("post_rst_idle");
      chk("post_rst_ready", 32'(ready_out), 32'd1);
    end
    push(8'h96);
    check_frame(8'h96, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_idle("post_rst_frame_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
